adder_pipe: RTL and testbench

//  Parametrised, pipelined add/sub/accumulate unit with valid/ready handshake on both sides.

---
 rtl/adder_pipe.sv | 182 ++++++++++++++++++
 tb/tb_adder_pipe.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe.sv
//------------------------------------------------------------------------------
// adder_pipe
//
// Pipelined add / subtract / accumulate unit with a valid/ready handshake on
// both sides. It sits between an operand producer and a result consumer in a
// single clock domain. Arithmetic is evaluated when a beat is accepted, and
// the result then travels unchanged through DEPTH register stages.
//
// Parameters
//   WIDTH  operand width in bits (>= 1)
//   ACC_W  result / accumulator width in bits (>= WIDTH+1)
//   DEPTH  register stages from input acceptance to output (>= 1)
//
// Ports
//   clk        in   1      clock, rising edge
//   rstx       in   1      asynchronous active-low reset
//   operand_a  in   WIDTH  unsigned operand A
//   operand_b  in   WIDTH  unsigned operand B
//   op         in   2      00 ADD, 01 SUB, 10 ACC, 11 CLR
//   in_valid   in   1      input beat present
//   in_ready   out  1      a beat can be accepted this cycle
//   result     out  ACC_W  result of the oldest beat in the output stage
//   flag       out  1      carry (ADD/ACC) or borrow (SUB) of that beat
//   out_valid  out  1      result/flag valid
//   out_ready  in   1      consumer takes the result this cycle
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module adder_pipe #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned ACC_W = 8,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rstx,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [1:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] result,
    output logic             flag,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    // Running accumulator, touched only by accepted ACC / CLR beats.
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    // Pipeline stage storage; index 0 is the acceptance stage,
    // index DEPTH-1 drives the outputs.
    logic [ACC_W-1:0] stg_res_q  [DEPTH];
    logic             stg_flag_q [DEPTH];
    logic [DEPTH-1:0] stg_v_q;

    // stg_move[k]: stage k may hand its content onward this cycle.
    // stg_load[k]: stage k captures a new beat this cycle.
    logic [DEPTH-1:0] stg_move;
    logic [DEPTH-1:0] stg_load;

    logic             accept;
    op_e              op_sel;
    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] b_ext;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] s1_res;
    logic             s1_flag;

    //--------------------------------------------------------------------------
    // Handshake / advance chain
    //--------------------------------------------------------------------------
    // The "may move" condition ripples from the output back towards the input:
    // the last stage moves on out_ready, every earlier stage moves when its
    // successor is empty or itself moving. A single running variable carries
    // the ripple so no vector bit depends on another bit of the same vector.
    always_comb begin
        logic        chain;
        int unsigned idx;
        stg_move = '0;
        stg_load = '0;
        chain    = out_ready;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx           = DEPTH - 1 - k;
            stg_move[idx] = chain;
            chain         = !stg_v_q[idx] || chain;
        end
        in_ready = chain;
        accept   = in_valid && chain;

        stg_load[0] = accept;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            stg_load[k] = stg_v_q[k-1] && stg_move[k-1];
        end
    end

    //--------------------------------------------------------------------------
    // Stage-1 arithmetic
    //--------------------------------------------------------------------------
    assign op_sel  = op_e'(op);
    assign a_ext   = ACC_W'(operand_a);
    assign b_ext   = ACC_W'(operand_b);
    // One extra bit holds the wrap of the accumulator; a+b alone can never
    // exceed ACC_W bits, so at most a single carry appears here.
    assign acc_sum = {1'b0, acc_q} + {1'b0, a_ext} + {1'b0, b_ext};

    always_comb begin
        s1_res  = '0;
        s1_flag = 1'b0;
        acc_d   = acc_q;
        unique case (op_sel)
            OP_ADD: begin
                s1_res = a_ext + b_ext;
            end
            OP_SUB: begin
                s1_res  = a_ext - b_ext;
                s1_flag = operand_a < operand_b;
            end
            OP_ACC: begin
                s1_res  = acc_sum[ACC_W-1:0];
                s1_flag = acc_sum[ACC_W];
                acc_d   = acc_sum[ACC_W-1:0];
            end
            OP_CLR: begin
                acc_d = '0;
            end
            default: begin
                acc_d = acc_q;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // State registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            acc_q   <= '0;
            stg_v_q <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stg_res_q[k]  <= '0;
                stg_flag_q[k] <= 1'b0;
            end
        end else begin
            if (accept) begin
                acc_q <= acc_d;
            end

            // A stage stays full if it holds a beat that cannot move, and
            // becomes full whenever it loads; otherwise it empties.
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stg_v_q[k] <= stg_load[k] || (stg_v_q[k] && !stg_move[k]);
            end

            if (stg_load[0]) begin
                stg_res_q[0]  <= s1_res;
                stg_flag_q[0] <= s1_flag;
            end
            for (int unsigned k = 1; k < DEPTH; k++) begin
                if (stg_load[k]) begin
                    stg_res_q[k]  <= stg_res_q[k-1];
                    stg_flag_q[k] <= stg_flag_q[k-1];
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign result    = stg_res_q[DEPTH-1];
    assign flag      = stg_flag_q[DEPTH-1];
    assign out_valid = stg_v_q[DEPTH-1];

endmodule

// File: tb/tb_adder_pipe.sv
`timescale 1ns/1ps

module tb_adder_pipe;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;
    localparam int NBEATS = 10000;

    logic clk;
    logic rstx;

    // Default configuration: WIDTH=3, ACC_W=8, DEPTH=1
    logic [2:0]  a1, b1;
    logic [1:0]  op1;
    logic        iv1, ir1, fl1, ov1, or1;
    logic [7:0]  res1;

    // DEPTH=3
    logic [2:0]  a3, b3;
    logic [1:0]  op3;
    logic        iv3, ir3, fl3, ov3, or3;
    logic [7:0]  res3;

    // WIDTH=5, ACC_W=12, DEPTH=4
    logic [4:0]  a4, b4;
    logic [1:0]  op4;
    logic        iv4, ir4, fl4, ov4, or4;
    logic [11:0] res4;

    int n_vec;
    int n_err;

    adder_pipe u_dut1 (
        .clk(clk), .rstx(rstx), .operand_a(a1), .operand_b(b1), .op(op1),
        .in_valid(iv1), .in_ready(ir1), .result(res1), .flag(fl1),
        .out_valid(ov1), .out_ready(or1)
    );

    adder_pipe #(.WIDTH(3), .ACC_W(8), .DEPTH(3)) u_dut3 (
        .clk(clk), .rstx(rstx), .operand_a(a3), .operand_b(b3), .op(op3),
        .in_valid(iv3), .in_ready(ir3), .result(res3), .flag(fl3),
        .out_valid(ov3), .out_ready(or3)
    );

    adder_pipe #(.WIDTH(5), .ACC_W(12), .DEPTH(4)) u_dut4 (
        .clk(clk), .rstx(rstx), .operand_a(a4), .operand_b(b4), .op(op4),
        .in_valid(iv4), .in_ready(ir4), .result(res4), .flag(fl4),
        .out_valid(ov4), .out_ready(or4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one beat to u_dut1 and return #1 after the accepting edge.
    task automatic send1(input logic [1:0] o, input logic [2:0] a, input logic [2:0] b);
        int t;
        t   = 0;
        op1 = o;
        a1  = a;
        b1  = b;
        iv1 = 1'b1;
        while (!ir1 && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 20) check("send1_timeout", 32'(t), 32'(0));
        @(posedge clk);
        #1;
        iv1 = 1'b0;
    endtask

    task automatic chk1(input string tag, input int r, input int f);
        check({tag, "_v"}, 32'(ov1), 32'(1));
        check({tag, "_res"}, 32'(res1), 32'(r));
        check({tag, "_flag"}, 32'(fl1), 32'(f));
    endtask

    initial begin
        int          nacc;
        int          seen;
        int          lat;
        logic        was;
        logic [7:0]  got_q[$];

        n_vec = 0;
        n_err = 0;
        rstx = 1'b0;
        a1 = '0; b1 = '0; op1 = OP_ADD; iv1 = 1'b0; or1 = 1'b1;
        a3 = '0; b3 = '0; op3 = OP_ADD; iv3 = 1'b0; or3 = 1'b0;
        a4 = '0; b4 = '0; op4 = OP_ADD; iv4 = 1'b0; or4 = 1'b0;

        // Reset state
        #1;
        check("rst_ov", 32'(ov1), 32'(0));
        check("rst_res", 32'(res1), 32'(0));
        check("rst_flag", 32'(fl1), 32'(0));
        check("rst_ir", 32'(ir1), 32'(1));
        @(negedge clk);
        rstx = 1'b1;
        @(posedge clk);
        #1;

        // ADD 7+7, then 8 back-to-back beats
        send1(OP_ADD, 3'd7, 3'd7);
        chk1("add77", 14, 0);
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                iv1 = 1'b1; op1 = OP_ADD; a1 = 3'(i); b1 = 3'(i);
            end else begin
                iv1 = 1'b0;
            end
            @(posedge clk);
            #1;
            if (i < 8) begin
                check("b2b_v", 32'(ov1), 32'(1));
                check("b2b_res", 32'(res1), 32'(2 * i));
            end
        end
        check("b2b_drain", 32'(ov1), 32'(0));

        // SUB
        send1(OP_SUB, 3'd2, 3'd5);
        chk1("sub25", 8'hFD, 1);
        send1(OP_SUB, 3'd5, 3'd2);
        chk1("sub52", 3, 0);

        // CLR then ACC 7+7 x19 with a wrap, ADD interleaved
        send1(OP_CLR, 3'd5, 3'd5);
        chk1("clr", 0, 0);
        for (int i = 0; i < 19; i++) begin
            if (i == 5) begin
                send1(OP_ADD, 3'd1, 3'd2);
                chk1("acc_add", 3, 0);
            end
            send1(OP_ACC, 3'd7, 3'd7);
            chk1("acc", (14 * (i + 1)) % 256, (14 * (i + 1)) >= 256 ? 1 : 0);
        end

        // Reset mid-stream on the DEPTH=3 instance with two beats in flight
        iv3 = 1'b1; op3 = OP_ACC; a3 = 3'd3; b3 = 3'd4;
        @(posedge clk);
        #1;
        a3 = 3'd1; b3 = 3'd1;
        @(posedge clk);
        #1;
        iv3 = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_ov", 32'(ov3), 32'(1));
        check("pre_rst_res", 32'(res3), 32'(7));
        #2;
        rstx = 1'b0;
        #1;
        check("mid_rst_ov", 32'(ov3), 32'(0));
        check("mid_rst_res", 32'(res3), 32'(0));
        check("mid_rst_flag", 32'(fl3), 32'(0));
        @(negedge clk);
        rstx = 1'b1;
        or3  = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (ov3) seen++;
        end
        check("no_stale", 32'(seen), 32'(0));
        iv3 = 1'b1; op3 = OP_ACC; a3 = 3'd1; b3 = 3'd1;
        @(posedge clk);
        #1;
        iv3 = 1'b0;
        lat = 0;
        while (!ov3 && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("post_rst_lat", 32'(lat), 32'(2));
        check("post_rst_res", 32'(res3), 32'(2));
        check("post_rst_flag", 32'(fl3), 32'(0));
        @(posedge clk);
        #1;
        or3 = 1'b0;

        // Backpressure on DEPTH=3
        nacc = 0;
        iv3  = 1'b1;
        op3  = OP_ADD;
        for (int c = 0; c < 8; c++) begin
            a3  = 3'(nacc + 1);
            b3  = 3'd0;
            was = ir3;
            @(posedge clk);
            #1;
            if (was) nacc++;
        end
        iv3 = 1'b0;
        check("bp_accepts", 32'(nacc), 32'(3));
        check("bp_ir", 32'(ir3), 32'(0));
        check("bp_ov", 32'(ov3), 32'(1));
        check("bp_res", 32'(res3), 32'(1));
        repeat (3) @(posedge clk);
        #1;
        check("bp_hold_ov", 32'(ov3), 32'(1));
        check("bp_hold_res", 32'(res3), 32'(1));
        or3 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (ov3) got_q.push_back(res3);
            @(posedge clk);
            #1;
        end
        check("bp_count", 32'(got_q.size()), 32'(3));
        for (int i = 0; i < 3; i++) begin
            if (got_q.size() > 0) check("bp_order", 32'(got_q.pop_front()), 32'(i + 1));
        end

        // Random traffic on WIDTH=5, ACC_W=12, DEPTH=4 against a reference model
        begin
            int          sent;
            int          got;
            int          cyc;
            int          s;
            logic [11:0] macc;
            logic [11:0] er;
            logic        ef;
            logic [12:0] sb[$];
            logic [12:0] e;
            sent = 0; got = 0; cyc = 0; macc = '0;
            while ((sent < NBEATS || sb.size() > 0) && cyc < 60000) begin
                @(posedge clk);
                #1;
                cyc++;
                or4 = 1'($urandom_range(0, 1));
                if (sent < NBEATS) begin
                    iv4 = 1'($urandom_range(0, 1));
                    a4  = 5'($urandom);
                    b4  = 5'($urandom);
                    op4 = 2'($urandom);
                end else begin
                    iv4 = 1'b0;
                end
                @(negedge clk);
                if (iv4 && ir4) begin
                    ef = 1'b0;
                    er = '0;
                    case (op4)
                        OP_ADD: er = 12'(int'(a4) + int'(b4));
                        OP_SUB: begin
                            er = 12'(int'(a4) - int'(b4));
                            ef = (a4 < b4);
                        end
                        OP_ACC: begin
                            s    = int'(macc) + int'(a4) + int'(b4);
                            ef   = (s >= 4096);
                            macc = 12'(s);
                            er   = macc;
                        end
                        default: macc = '0;
                    endcase
                    sb.push_back({ef, er});
                    sent++;
                end
                if (ov4 && or4) begin
                    if (sb.size() == 0) begin
                        check("sb_spurious", 32'(ov4), 32'(0));
                    end else begin
                        e = sb.pop_front();
                        check("sb_res", 32'(res4), 32'(e[11:0]));
                        check("sb_flag", 32'(fl4), 32'(e[12]));
                        got++;
                    end
                end
            end
            check("sb_count", 32'(got), 32'(NBEATS));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
